tdm_demux8: RTL and testbench

//   Receive end of the 8:1 select-multiplexed serial link. Accepts one slot per

---
 rtl/tdm_demux8_pkg.sv | 15 +
 rtl/tdm_demux8_if.sv | 28 ++
 rtl/tdm_demux8_slot_ctr.sv | 33 +++
 rtl/tdm_demux8.sv | 115 +++++++++++
 tb/tb_tdm_demux8.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux8_pkg.sv
// Shared constants and types for the 8-slot TDM receive demultiplexer.
// Slot count is fixed at 8, so the slot index is 3 bits wide.
package tdm_demux8_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] slot_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  localparam slot_t LAST_SLOT = slot_t'(LANES - 1);
endpackage

// File: rtl/tdm_demux8_if.sv
// Link-side inputs and frame-side outputs of the TDM demultiplexer.
// The master modport drives serial beats; the slave modport is the receiver.
interface tdm_demux8_if
  import tdm_demux8_pkg::*;
#(
  parameter int W     = 1,
  parameter int ERR_W = 8
);
  logic                 din_valid;
  logic                 sof;
  logic [W-1:0]         din;
  slot_t                slot;
  logic                 busy;
  logic [LANES*W-1:0]   dout;
  logic                 dout_valid;
  logic                 frame_err;
  logic [ERR_W-1:0]     err_count;

  modport master (
    output din_valid, sof, din,
    input  slot, busy, dout, dout_valid, frame_err, err_count
  );

  modport slave (
    input  din_valid, sof, din,
    output slot, busy, dout, dout_valid, frame_err, err_count
  );
endinterface

// File: rtl/tdm_demux8_slot_ctr.sv
// Slot index counter: load-to-1 for a new frame, clear at frame end, else increment.
// Load outranks clear, which outranks increment.
module tdm_slot_ctr
  import tdm_demux8_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load1,
  input  logic  clr,
  input  logic  inc,
  output slot_t slot
);
  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load1)
      slot_d = slot_t'(1);
    else if (clr)
      slot_d = '0;
    else if (inc)
      slot_d = slot_q + slot_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      slot_q <= '0;
    else
      slot_q <= slot_d;
  end

  assign slot = slot_q;
endmodule

// File: rtl/tdm_demux8.sv
// TDM receiver: collects 8 slots after a start-of-frame marker and publishes them
// as one registered word, flagging and counting frames broken by an early SOF.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int W     = 1,
  parameter int ERR_W = 8
)(
  input  logic         clk,
  input  logic         rst,
  tdm_demux8_if.slave  bus
);
  state_e               state_q, state_d;
  logic [LANES*W-1:0]   dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;
  logic [W-1:0]         shadow_q [LANES-1];
  logic [LANES*W-1:0]   frame_word;
  logic                 load1, clr, inc, shadow_we;
  slot_t                shadow_idx;
  slot_t                slot;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .load1 (load1),
    .clr   (clr),
    .inc   (inc),
    .slot  (slot)
  );

  // The last lane never lands in shadow: it goes straight from din into dout.
  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : g_shadow
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          shadow_q[gi] <= '0;
        else if (shadow_we && shadow_idx == slot_t'(gi))
          shadow_q[gi] <= bus.din;
      end
      assign frame_word[gi*W +: W] = shadow_q[gi];
    end
  endgenerate
  assign frame_word[(LANES-1)*W +: W] = bus.din;

  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    load1        = 1'b0;
    clr          = 1'b0;
    inc          = 1'b0;
    shadow_we    = 1'b0;
    shadow_idx   = slot;
    case (state_q)
      ST_IDLE: begin
        if (bus.din_valid && bus.sof) begin
          shadow_we  = 1'b1;
          shadow_idx = '0;
          load1      = 1'b1;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.din_valid) begin
          if (bus.sof) begin
            // Early SOF: drop the partial frame and restart on this beat.
            frame_err_d = 1'b1;
            if (err_count_q != '1)
              err_count_d = err_count_q + ERR_W'(1);
            shadow_we  = 1'b1;
            shadow_idx = '0;
            load1      = 1'b1;
          end else if (slot == LAST_SLOT) begin
            dout_d       = frame_word;
            dout_valid_d = 1'b1;
            clr          = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            shadow_we = 1'b1;
            inc       = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.slot       = slot;
  assign bus.busy       = (state_q == ST_COLLECT);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8: framing, gaps, early SOF,
// async reset mid-frame, back-to-back frames and error-counter saturation.
module tb_tdm_demux8;
  import tdm_demux8_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  tdm_demux8_if #(.W(1), .ERR_W(8)) bus ();

  tdm_demux8 #(.W(1), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one beat mid-cycle, then return 1 time unit after the capturing edge.
  task automatic beat(input logic v, input logic s, input logic d);
    @(negedge clk);
    bus.din_valid = v;
    bus.sof       = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: dout=%h dv=%b fe=%b required 00/0/0", bus.dout, bus.dout_valid, bus.frame_err);
    end
    n_checks++;
    if (bus.slot !== 3'd0 || bus.busy !== 1'b0 || bus.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: slot=%0d busy=%b ec=%0d required 0/0/0", bus.slot, bus.busy, bus.err_count);
    end
    n_checks++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame;
    logic [7:0] word;
    word = 8'b1011_0101;
    for (int k = 0; k < 8; k++) begin
      beat(1'b1, k == 0, word[k]);
      if (k < 7) begin
        n_checks++;
        if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b1 || bus.slot !== 3'(k + 1)) begin
          n_fail++;
          $display("FAIL basic_beat%0d: dv=%b busy=%b slot=%0d required 0/1/%0d", k, bus.dout_valid, bus.busy, bus.slot, k + 1);
        end
      end
    end
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hB5 || bus.busy !== 1'b0 || bus.slot !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_publish: dv=%b dout=%h busy=%b slot=%0d required 1/b5/0/0", bus.dout_valid, bus.dout, bus.busy, bus.slot);
    end
    $display("basic frame: dout=%h", bus.dout);
    beat(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 8'hB5) begin
      n_fail++;
      $display("FAIL basic_hold: dv=%b dout=%h required 0/b5", bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] word;
    int         t0;
    word = 8'b1011_0101;
    t0   = cyc;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        for (int g = 0; g < 3; g++) begin
          beat(1'b0, 1'b0, 1'b1);
          n_checks++;
          if (bus.busy !== 1'b1 || bus.slot !== 3'd3 || bus.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_hold%0d: busy=%b slot=%0d dv=%b required 1/3/0", g, bus.busy, bus.slot, bus.dout_valid);
          end
        end
      end
      beat(1'b1, k == 0, word[k]);
    end
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hB5 || cyc - t0 !== 11) begin
      n_fail++;
      $display("FAIL gap_publish: dv=%b dout=%h cycles=%0d required 1/b5/11", bus.dout_valid, bus.dout, cyc - t0);
    end
    $display("gapped frame: dout=%h after %0d cycles", bus.dout, cyc - t0);
  endtask

  task automatic test_early_sof;
    beat(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.frame_err !== 1'b1 || bus.err_count !== 8'd1 || bus.dout_valid !== 1'b0 || bus.slot !== 3'd1) begin
      n_fail++;
      $display("FAIL early_sof: fe=%b ec=%0d dv=%b slot=%0d required 1/1/0/1", bus.frame_err, bus.err_count, bus.dout_valid, bus.slot);
    end
    n_checks++;
    if (bus.dout !== 8'hB5 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_sof_hold: dout=%h busy=%b required b5/1", bus.dout, bus.busy);
    end
    for (int k = 1; k < 8; k++) begin
      beat(1'b1, 1'b0, 1'b1);
      if (k < 7) begin
        n_checks++;
        if (bus.dout_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_beat%0d: dv=%b fe=%b required 0/0", k, bus.dout_valid, bus.frame_err);
        end
      end
    end
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hFF || bus.err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_publish: dv=%b dout=%h ec=%0d required 1/ff/1", bus.dout_valid, bus.dout, bus.err_count);
    end
    $display("restarted frame: dout=%h err_count=%0d", bus.dout, bus.err_count);
  endtask

  task automatic test_idle_drop;
    for (int k = 0; k < 3; k++) begin
      beat(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus.slot !== 3'd0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.dout !== 8'hFF || bus.frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_drop%0d: slot=%0d busy=%b dv=%b dout=%h fe=%b required 0/0/0/ff/0", k, bus.slot, bus.busy, bus.dout_valid, bus.dout, bus.frame_err);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] word;
    beat(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) beat(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.slot !== 3'd5) begin
      n_fail++;
      $display("FAIL pre_reset_slot: slot=%0d required 5", bus.slot);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.slot !== 3'd0 || bus.busy !== 1'b0 || bus.dout !== 8'h00 || bus.err_count !== 8'd0 || bus.dout_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: slot=%0d busy=%b dout=%h ec=%0d dv=%b fe=%b required all 0", bus.slot, bus.busy, bus.dout, bus.err_count, bus.dout_valid, bus.frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    word = 8'h5A;
    for (int k = 0; k < 8; k++) beat(1'b1, k == 0, word[k]);
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h5A || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_frame: dv=%b dout=%h fe=%b required 1/5a/0", bus.dout_valid, bus.dout, bus.frame_err);
    end
    $display("post-reset frame: dout=%h", bus.dout);
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [2];
    int         t_pulse [2];
    int         pulses;
    int         exp_ec;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    pulses   = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        beat(1'b1, k == 0, words[f][k]);
        if (bus.dout_valid === 1'b1) pulses++;
      end
      t_pulse[f] = cyc;
      n_checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== words[f]) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: dv=%b dout=%h required 1/%h", f, bus.dout_valid, bus.dout, words[f]);
      end
      $display("back-to-back frame %0d: dout=%h", f, bus.dout);
    end
    n_checks++;
    if (t_pulse[1] - t_pulse[0] !== 8 || pulses !== 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: spacing=%0d pulses=%0d required 8/2", t_pulse[1] - t_pulse[0], pulses);
    end
    beat(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.frame_err !== 1'b0 || bus.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL sat_start: fe=%b ec=%0d required 0/0", bus.frame_err, bus.err_count);
    end
    for (int i = 0; i < 260; i++) begin
      beat(1'b1, 1'b1, 1'b1);
      exp_ec = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if (bus.frame_err !== 1'b1 || bus.dout_valid !== 1'b0 || bus.err_count !== 8'(exp_ec)) begin
        n_fail++;
        $display("FAIL sat_err%0d: fe=%b dv=%b ec=%0d required 1/0/%0d", i, bus.frame_err, bus.dout_valid, bus.err_count, exp_ec);
      end
    end
    $display("error counter after 260 forced errors: %0d", bus.err_count);
    beat(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.din       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_early_sof();
    test_idle_drop();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
